// File: rtl/z80_arb_pkg.sv
// ============================================================================
//  Module : z80_arb_pkg
//  Brief  : Shared state type and counter widths for the Z80 BUSRQ arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package z80_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int BURST_W = 8;
    localparam int GAP_W   = 8;

endpackage

`default_nettype wire

// File: rtl/arb_rr_pick.sv
// ============================================================================
//  Module : arb_rr_pick
//  Brief  : Combinational winner select: first set request at or above the
//           round-robin pointer, wrapping. ARB_FIXED_PRIO_EN: lowest index wins.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_rr_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 1
) (
`ifndef ARB_FIXED_PRIO_EN
    input  logic [PTR_W-1:0] i_ptr,
`endif
    input  logic [NREQ-1:0]  i_req,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_valid
);

    assign o_valid = |i_req;

    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        int t;
        o_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef ARB_FIXED_PRIO_EN
            t = k;
`else
            t = int'(i_ptr) + k;
            if (t >= NREQ) begin
                t = t - NREQ;
            end
`endif
            if (i_req[PTR_W'(t)]) begin
                o_idx = PTR_W'(t);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/z80_busrq_arbiter.sv
// ============================================================================
//  Module : z80_busrq_arbiter
//  Brief  : Shares the Z80 bus between the CPU and NREQ DMA requesters via
//           nBUSRQ/nBUSACK, with burst limit and CPU gap. Optional macro
//           ARB_FIXED_PRIO_EN selects fixed (lowest-index) priority.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module z80_busrq_arbiter
    import z80_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 16,
    parameter int MIN_GAP   = 4
) (
    input  logic            CLK,
    input  logic            nRESET,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] xfer,
    input  logic            nBUSACK,
    output logic            nBUSRQ,
    output logic [NREQ-1:0] grant,
    output logic            bus_owned,
    output logic            busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t          r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_winner, w_winner_nxt;
    logic [PTR_W-1:0]    w_pick_idx;
    logic                w_pick_valid;
    logic [BURST_W-1:0]  r_burst_cnt, w_burst_nxt;
    logic [GAP_W-1:0]    r_gap_cnt, w_gap_nxt;
    logic                r_nbusrq, r_owned, r_busy;
    logic [NREQ-1:0]     r_grant, w_grant_nxt;
    logic                w_win_req, w_win_xfer, w_last_xfer;
`ifndef ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]    r_rr_ptr, w_rr_nxt;
`endif

    arb_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
`ifndef ARB_FIXED_PRIO_EN
        .i_ptr   (r_rr_ptr),
`endif
        .i_req   (req),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_win_req   = req[r_winner];
    assign w_win_xfer  = xfer[r_winner];
    assign w_last_xfer = w_win_xfer && (r_burst_cnt == BURST_W'(MAX_BURST - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_winner_nxt = r_winner;
        w_burst_nxt  = r_burst_cnt;
        w_gap_nxt    = r_gap_cnt;
`ifndef ARB_FIXED_PRIO_EN
        w_rr_nxt     = r_rr_ptr;
`endif
        case (r_state)
            IDLE: begin
                if (r_gap_cnt != '0) begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end else if (w_pick_valid) begin
                    w_winner_nxt = w_pick_idx;
                    w_state_nxt  = REQ;
                end
            end
            REQ: begin
                if (!w_win_req) begin
                    w_state_nxt = RELEASE;
                end else if (!nBUSACK) begin
                    w_state_nxt = GRANT;
                    w_burst_nxt = '0;
`ifndef ARB_FIXED_PRIO_EN
                    w_rr_nxt    = (r_winner == PTR_W'(NREQ - 1)) ? '0 : r_winner + 1'b1;
`endif
                end
            end
            GRANT: begin
                // An early nBUSACK rise is a protocol error; treat it as a release.
                if (nBUSACK || !w_win_req || w_last_xfer) begin
                    w_state_nxt = RELEASE;
                end else if (w_win_xfer) begin
                    w_burst_nxt = r_burst_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (nBUSACK) begin
                    w_state_nxt = IDLE;
                    w_gap_nxt   = GAP_W'(MIN_GAP);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_grant_nxt = (w_state_nxt == GRANT) ? (NREQ'(1) << r_winner) : '0;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state     <= IDLE;
            r_winner    <= '0;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
            r_nbusrq    <= 1'b1;
            r_grant     <= '0;
            r_owned     <= 1'b0;
            r_busy      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            r_rr_ptr    <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_winner    <= w_winner_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_nbusrq    <= !((w_state_nxt == REQ) || (w_state_nxt == GRANT));
            r_grant     <= w_grant_nxt;
            r_owned     <= (w_state_nxt == GRANT);
            r_busy      <= (w_state_nxt != IDLE);
`ifndef ARB_FIXED_PRIO_EN
            r_rr_ptr    <= w_rr_nxt;
`endif
        end
    end

    assign nBUSRQ    = r_nbusrq;
    assign grant     = r_grant;
    assign bus_owned = r_owned;
    assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_z80_busrq_arbiter.sv
// ============================================================================
//  Module : tb_z80_busrq_arbiter
//  Brief  : Self-checking bench for z80_busrq_arbiter with a tenure-level
//           reference model, a Z80 BUSRQ/BUSACK responder and random traffic.
//  Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_z80_busrq_arbiter;

    localparam int NREQ      = 2;
    localparam int MAX_BURST = 16;
    localparam int MIN_GAP   = 4;

    logic            CLK = 1'b0;
    logic            nRESET;
    logic [NREQ-1:0] req, xfer;
    logic            nBUSACK;
    logic            nBUSRQ, bus_owned, busy;
    logic [NREQ-1:0] grant;

    z80_busrq_arbiter #(
        .NREQ      (NREQ),
        .MAX_BURST (MAX_BURST),
        .MIN_GAP   (MIN_GAP)
    ) dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .req       (req),
        .xfer      (xfer),
        .nBUSACK   (nBUSACK),
        .nBUSRQ    (nBUSRQ),
        .grant     (grant),
        .bus_owned (bus_owned),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a tenure is "asking", "owning" or "giving back".
    bit m_asking, m_owning, m_giving;
    int m_who, m_start, m_left, m_gap;

    task automatic m_reset();
        m_asking = 0; m_owning = 0; m_giving = 0;
        m_who = 0; m_start = 0; m_left = 0; m_gap = 0;
    endtask

    task automatic m_step(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] xf, input logic ack_n);
        int c;
        if (m_owning) begin
            if (ack_n || !rq[m_who] || (xf[m_who] && m_left == 1)) begin
                m_owning = 0; m_asking = 0; m_giving = 1;
            end else if (xf[m_who]) begin
                m_left--;
            end
        end else if (m_asking) begin
            if (!rq[m_who]) begin
                m_asking = 0; m_giving = 1;
            end else if (!ack_n) begin
                m_owning = 1; m_left = MAX_BURST; m_start = (m_who + 1) % NREQ;
            end
        end else if (m_giving) begin
            if (ack_n) begin
                m_giving = 0; m_gap = MIN_GAP;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (rq != '0) begin
`ifdef ARB_FIXED_PRIO_EN
            c = 0;
`else
            c = m_start;
`endif
            while (!rq[c]) c = (c + 1) % NREQ;
            m_who = c;
            m_asking = 1;
        end
    endtask

    // Z80 side: acknowledge ack_dly clocks after nBUSRQ falls, release rel_dly after it rises.
    int  ack_dly = 3, rel_dly = 1, a_cnt = 0;
    bit  rnd_mode = 0;

    task automatic drive_ack();
        if (!nBUSRQ && nBUSACK) begin
            if (a_cnt >= ack_dly) begin
                nBUSACK = 1'b0; a_cnt = 0;
                if (rnd_mode) ack_dly = $urandom_range(0, 4);
            end else a_cnt++;
        end else if (nBUSRQ && !nBUSACK) begin
            if (a_cnt >= rel_dly) begin
                nBUSACK = 1'b1; a_cnt = 0;
                if (rnd_mode) rel_dly = $urandom_range(0, 3);
            end else a_cnt++;
        end else begin
            a_cnt = 0;
            if (rnd_mode && !nBUSRQ && !nBUSACK && grant != '0 && $urandom_range(0, 299) == 0)
                nBUSACK = 1'b1;
        end
    endtask

    int gq[$];
    int tq[$];
    int ten_cnt = 0;
    logic [NREQ-1:0] g_last = '0;

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic cyc();
        logic [NREQ-1:0] eg;
        @(posedge CLK);
        if (|(g_last & xfer)) ten_cnt++;
        if (!nRESET) m_reset();
        else m_step(req, xfer, nBUSACK);
        #1;
        eg = m_owning ? NREQ'(1 << m_who) : '0;
        chk("nbusrq", nBUSRQ, !m_asking);
        chk("grant", grant, eg);
        chk("bus_owned", bus_owned, m_owning);
        chk("busy", busy, m_asking | m_owning | m_giving);
        chk("grant_vs_nbusrq", (grant != '0) && nBUSRQ, 0);
        if (g_last == '0 && grant != '0) begin gq.push_back(int'(grant)); ten_cnt = 0; end
        if (g_last != '0 && grant == '0) tq.push_back(ten_cnt);
        g_last = grant;
        @(negedge CLK);
        drive_ack();
    endtask

    task automatic do_reset();
        nRESET = 1'b0; req = '0; xfer = '0; nBUSACK = 1'b1;
        repeat (2) cyc();
        nRESET = 1'b1;
        gq.delete(); tq.delete();
    endtask

    initial begin
        int n, idle;
        bit seen;
        m_reset();
        do_reset();
        chk("reset_nbusrq", nBUSRQ, 1);
        chk("reset_busy", busy, 0);

        // Single requester, three-clock acknowledge, transfer every cycle.
        ack_dly = 3; rel_dly = 1; req = 2'b01;
        for (int i = 0; i < 200 && tq.size() < 1; i++) begin cyc(); xfer = grant; end
        chk("p1_grant", qat(gq, 0), 1);
        chk("p1_burst", qat(tq, 0), MAX_BURST);
        idle = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(); xfer = grant;
            if (!busy) idle++;
            if (!nBUSRQ) break;
        end
        chk("p1_gap", idle, MIN_GAP + 1);

        // Both requesters held: four full tenures.
        do_reset();
        req = 2'b11;
        for (int i = 0; i < 600 && tq.size() < 4; i++) begin cyc(); xfer = grant; end
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            chk("p2_order", qat(gq, i), 1);
`else
            chk("p2_order", qat(gq, i), (i % 2 == 0) ? 1 : 2);
`endif
            chk("p2_burst", qat(tq, i), MAX_BURST);
        end

        // Requester 1 drops after five transfers while requester 0 is pending.
        do_reset();
        req = 2'b10; n = 0;
        for (int i = 0; i < 300 && gq.size() < 2; i++) begin
            cyc();
            xfer = '0;
            if (grant == 2'b10) begin
                req = 2'b11;
                if (n < 5) begin xfer = 2'b10; n++; end
                else req = 2'b01;
            end
        end
        chk("p3_first", qat(gq, 0), 2);
        chk("p3_next", qat(gq, 1), 1);
        chk("p3_burst", qat(tq, 0), 5);

        // Request withdrawn before the CPU acknowledges.
        do_reset();
        ack_dly = 20; req = 2'b01;
        for (int i = 0; i < 50 && nBUSRQ; i++) cyc();
        chk("p4_req_seen", nBUSRQ, 0);
        repeat (2) cyc();
        req = '0;
        repeat (40) cyc();
        chk("p4_nogrant", gq.size(), 0);
        chk("p4_idle", busy, 0);

        // Random traffic, including stray xfer bits and early nBUSACK rises.
        do_reset();
        rnd_mode = 1; ack_dly = 2; rel_dly = 1;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
            xfer = NREQ'($urandom);
        end
        chk("p5_grants_seen", gq.size() > 20, 1);
        rnd_mode = 0;

        // Asynchronous reset in the middle of a tenure.
        do_reset();
        ack_dly = 1; rel_dly = 1; req = 2'b01;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin cyc(); seen = (grant != '0); end
        chk("p6_granted", seen, 1);
        #2;
        nRESET = 1'b0;
        #1;
        chk("p6_async_nbusrq", nBUSRQ, 1);
        chk("p6_async_grant", grant, 0);
        chk("p6_async_owned", bus_owned, 0);
        req = '0; xfer = '0;
        repeat (2) cyc();
        nRESET = 1'b1;
        repeat (3) cyc();
        chk("p6_busy_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
